rex_sprite_engine: RTL and testbench
====================================

// Module: rex_sprite_engine
// PURPOSE
//  Parametrised player-sprite engine for the VGA game: owns the sprite position, jump physics and score,
//  and overlays the sprite on the background pixel stream. Sits between display_controller (hCount/vCount/bright)
//  and the VGA RGB output. Adds frame-locked motion, edge clamping, a jump FSM with gravity and saturating score.
// PARAMETERS
//  SPRITE_W   10       sprite width in pixels (even); HALF_W = SPRITE_W/2
//  SPRITE_H   10       sprite height in pixels (even); HALF_H = SPRITE_H/2
//  H_MIN      144      first visible hCount
//  H_MAX      783      last visible hCount
//  V_MIN      35       first visible vCount
//  X_START    450      sprite centre x after reset
//  GROUND_Y   400      sprite centre y when on ground
//  STEP       2        horizontal pixels per frame tick
//  JUMP_V     12       initial upward velocity (pixels/tick)
//  GRAVITY    1        velocity change per tick
//  MAX_FALL   12       fall velocity cap
//  COLOR      12'hF00  sprite colour
// PORTS
//  clk         in   1   pixel clock (25 MHz)
//  rst         in   1   asynchronous, active-low reset
//  up          in   1   jump request (level, sampled on frame tick)
//  down        in   1   fast-drop request
//  left        in   1   move left
//  right       in   1   move right
//  pause       in   1   freeze motion and score
//  hCount      in   10  current horizontal pixel counter
//  vCount      in   10  current vertical pixel counter
//  bright      in   1   1 = inside display area
//  background  in   12  background RGB for current pixel
//  xpos        out  10  sprite centre x
//  ypos        out  10  sprite centre y
//  score       out  16  frames survived (binary or BCD, see CONFIGURATION)
//  airborne    out  1   1 while state != GROUND
//  rgb         out  12  registered pixel colour
// BEHAVIOUR
//  Reset (rst=0, async): xpos=X_START, ypos=GROUND_Y, vel=0, state=GROUND, score=0, rgb=0, airborne=0.
//  Frame tick: 1-cycle internal pulse, the cycle after hCount==0 && vCount==0 is observed; all motion/score update only then.
//  pause=1: tick ignored for position, velocity, state and score; rgb path keeps running.
//  Horizontal: left&~right -> xpos-=STEP; right&~left -> xpos+=STEP; both/none -> hold.
//   Clamp to [H_MIN+HALF_W, H_MAX-HALF_W]; never wraps.
//  Jump FSM (per tick): GROUND: up -> RISE, vel=JUMP_V. RISE: ypos-=vel, vel-=GRAVITY; vel reaches 0 or down=1 -> FALL.
//   ypos clamped to >= V_MIN+HALF_H during RISE. FALL: vel=min(vel+GRAVITY,MAX_FALL), ypos+=vel;
//   if ypos+vel >= GROUND_Y -> ypos=GROUND_Y, vel=0, GROUND. up while airborne ignored.
//  Score: +1 per unpaused tick; saturates at 16'hFFFF (binary) / 16'h9999 (BCD); no wrap.
//  Pixel: fill = |hCount-xpos|<=HALF_W && |vCount-ypos|<=HALF_H (compare in 11-bit, no underflow).
//   rgb <= ~bright ? 0 : fill ? COLOR : background; latency 1 clk from hCount/vCount.
//  Simultaneous tick & reset: reset wins. Position updates are single-register writes per tick, so no mid-frame tearing beyond one line.
// CONFIGURATION
//  REX_SCORE_BCD_EN defined: score is 4-digit packed BCD, per-digit carry, saturate 9999 (16'h9999).
//  Not defined: plain 16-bit binary counter, saturate 16'hFFFF.
// STRUCTURE
//  rex_pkg: state enum {GROUND,RISE,FALL}, display constants H_MIN/H_MAX/V_MIN/V_MAX, COLOR defaults.
//  Sub-module rex_jump_fsm: owns state, vel, ypos; inputs tick/up/down/pause; top keeps x, score, pixel path.
// TESTING
//  1 Reset low mid-jump -> next cycle xpos=450, ypos=400, score=0, rgb=0, airborne=0.
//  2 right held 400 ticks -> xpos stops at 778 (783-5), never exceeds; left mirrors to 149.
//  3 up 1 tick from ground -> ypos min 400-78=322 after 12 ticks, returns to 400 exactly, airborne falls.
//  4 down asserted 3 ticks into RISE -> FALL next tick; ypos returns to 400 earlier than case 3.
//  5 hCount=xpos+5,vCount=ypos,bright=1 -> rgb=12'hF00 one clk later; xpos+6 -> background; bright=0 -> 0.
//  6 score preloaded near max, 5 ticks -> holds 16'hFFFF (16'h9999 with REX_SCORE_BCD_EN); pause=1 -> no change.

Source files
------------

// File: rtl/rex_sprite_engine_pkg.sv
// rex_pkg: shared types, display constants and the score helpers for the
// player-sprite engine.
//
// Configuration macro: REX_SCORE_BCD_EN
//   defined     -> score is 4-digit packed BCD and saturates at 16'h9999
//   not defined -> score is a plain 16-bit binary count and saturates at 16'hFFFF
package rex_pkg;

    // Jump state, also exported through the engine's state_dbg port.
    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } rex_state_e;

    // 640x480 timing as produced by display_controller.
    localparam int H_MIN_DEF = 144;
    localparam int H_MAX_DEF = 783;
    localparam int V_MIN_DEF = 35;
    localparam int V_MAX_DEF = 514;

    localparam logic [11:0] COLOR_DEF = 12'hF00;

`ifdef REX_SCORE_BCD_EN
    localparam logic [15:0] SCORE_MAX = 16'h9999;
`else
    localparam logic [15:0] SCORE_MAX = 16'hFFFF;
`endif

    // Packed-BCD increment with ripple carry between the four digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rex_sprite_engine_jump_fsm.sv
// rex_jump_fsm: vertical motion of the sprite (jump state, velocity, ypos).
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   tick              one-cycle frame pulse; all updates happen only on it
//   up, down, pause   jump request, fast drop, freeze
//   ypos              sprite centre y
//   state             current jump state
//   airborne          1 while state != ST_GROUND
module rex_jump_fsm
    import rex_pkg::*;
#(
    parameter int HALF_H   = 5,
    parameter int V_MIN    = V_MIN_DEF,
    parameter int GROUND_Y = 400,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       up,
    input  logic       down,
    input  logic       pause,
    output logic [9:0] ypos,
    output rex_state_e state,
    output logic       airborne
);

    localparam logic [9:0]  Y_TOP10    = 10'(V_MIN + HALF_H);
    localparam logic [10:0] Y_TOP11    = 11'(V_MIN + HALF_H);
    localparam logic [9:0]  GROUND10   = 10'(GROUND_Y);
    localparam logic [10:0] GROUND11   = 11'(GROUND_Y);
    localparam logic [7:0]  JUMP8      = 8'(JUMP_V);
    localparam logic [7:0]  GRAV8      = 8'(GRAVITY);
    localparam logic [7:0]  FALL_MAX8  = 8'(MAX_FALL);

    rex_state_e  state_q, state_d;
    logic [7:0]  vel_q, vel_d;
    logic [9:0]  ypos_q, ypos_d;

    logic [10:0] y_ext;
    logic [10:0] v_ext;
    logic [7:0]  fall_v;
    logic [10:0] y_sum;

    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        ypos_d  = ypos_q;
        y_ext   = {1'b0, ypos_q};
        v_ext   = {3'b000, vel_q};
        fall_v  = ((vel_q + GRAV8) > FALL_MAX8) ? FALL_MAX8 : (vel_q + GRAV8);
        y_sum   = y_ext + {3'b000, fall_v};

        if (tick && !pause) begin
            case (state_q)
                ST_GROUND: begin
                    if (up) begin
                        state_d = ST_RISE;
                        vel_d   = JUMP8;
                    end
                end
                ST_RISE: begin
                    // Move up first, then decelerate; a drop request still
                    // applies this tick's rise before switching to FALL.
                    if (y_ext < (v_ext + Y_TOP11)) begin
                        ypos_d = Y_TOP10;
                    end else begin
                        ypos_d = ypos_q - {2'b00, vel_q};
                    end
                    vel_d = (vel_q > GRAV8) ? (vel_q - GRAV8) : 8'd0;
                    if ((vel_d == 8'd0) || down) begin
                        state_d = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (y_sum >= GROUND11) begin
                        ypos_d  = GROUND10;
                        vel_d   = 8'd0;
                        state_d = ST_GROUND;
                    end else begin
                        ypos_d = y_sum[9:0];
                        vel_d  = fall_v;
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                    vel_d   = 8'd0;
                    ypos_d  = GROUND10;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_GROUND;
            vel_q   <= 8'd0;
            ypos_q  <= GROUND10;
        end else begin
            state_q <= state_d;
            vel_q   <= vel_d;
            ypos_q  <= ypos_d;
        end
    end

    assign ypos     = ypos_q;
    assign state    = state_q;
    assign airborne = (state_q != ST_GROUND);

endmodule

// File: rtl/rex_sprite_engine.sv
// rex_sprite_engine: player sprite for the VGA game. Owns horizontal
// position and score, delegates jump physics to rex_jump_fsm, and overlays
// the sprite on the background pixel stream with one clock of latency.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-low reset
//   up/down/left/right       controls, sampled on the frame tick
//   pause                    freezes motion and score (pixel path keeps running)
//   hCount, vCount, bright   raster position and display-area flag
//   background               background colour for the current pixel
//   xpos, ypos               sprite centre
//   score                    unpaused frames, saturating
//   airborne                 1 while the sprite is off the ground
//   rgb                      registered output colour
//   state_dbg                jump state (rex_state_e encoding)
//
// Configuration macro: REX_SCORE_BCD_EN selects a packed-BCD score.
module rex_sprite_engine
    import rex_pkg::*;
#(
    parameter int          SPRITE_W = 10,
    parameter int          SPRITE_H = 10,
    parameter int          H_MIN    = H_MIN_DEF,
    parameter int          H_MAX    = H_MAX_DEF,
    parameter int          V_MIN    = V_MIN_DEF,
    parameter int          X_START  = 450,
    parameter int          GROUND_Y = 400,
    parameter int          STEP     = 2,
    parameter int          JUMP_V   = 12,
    parameter int          GRAVITY  = 1,
    parameter int          MAX_FALL = 12,
    parameter logic [11:0] COLOR    = COLOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        pause,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    input  logic [11:0] background,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic [15:0] score,
    output logic        airborne,
    output logic [11:0] rgb,
    output logic [1:0]  state_dbg
);

    localparam int          HALF_W  = SPRITE_W / 2;
    localparam int          HALF_H  = SPRITE_H / 2;
    localparam logic [9:0]  X_LO    = 10'(H_MIN + HALF_W);
    localparam logic [9:0]  X_HI    = 10'(H_MAX - HALF_W);
    localparam logic [9:0]  STEP10  = 10'(STEP);
    localparam logic [10:0] HALF_W11 = 11'(HALF_W);
    localparam logic [10:0] HALF_H11 = 11'(HALF_H);

    logic        frame_q, frame_d;
    logic [9:0]  xpos_q, xpos_d;
    logic [15:0] score_q, score_d;
    logic [11:0] rgb_q, rgb_d;
    logic        tick;
    rex_state_e  jump_state;

    logic [10:0] h_ext, v_ext, x_ext, y_ext, dx, dy;
    logic        fill;

    // Frame tick is the registered version of the (0,0) raster position.
    assign tick = frame_q;

    rex_jump_fsm #(
        .HALF_H   (HALF_H),
        .V_MIN    (V_MIN),
        .GROUND_Y (GROUND_Y),
        .JUMP_V   (JUMP_V),
        .GRAVITY  (GRAVITY),
        .MAX_FALL (MAX_FALL)
    ) u_jump (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .up       (up),
        .down     (down),
        .pause    (pause),
        .ypos     (ypos),
        .state    (jump_state),
        .airborne (airborne)
    );

    always_comb begin
        frame_d = (hCount == 10'd0) && (vCount == 10'd0);
        xpos_d  = xpos_q;
        score_d = score_q;

        if (tick && !pause) begin
            // Clamp compares are arranged so nothing wraps near either edge.
            if (left && !right) begin
                xpos_d = (xpos_q < (X_LO + STEP10)) ? X_LO : (xpos_q - STEP10);
            end else if (right && !left) begin
                xpos_d = (xpos_q > (X_HI - STEP10)) ? X_HI : (xpos_q + STEP10);
            end

            if (score_q != SCORE_MAX) begin
`ifdef REX_SCORE_BCD_EN
                score_d = bcd_inc(score_q);
`else
                score_d = score_q + 16'd1;
`endif
            end
        end
    end

    // Pixel overlay: absolute distances in 11 bits so no operand underflows.
    always_comb begin
        h_ext = {1'b0, hCount};
        v_ext = {1'b0, vCount};
        x_ext = {1'b0, xpos_q};
        y_ext = {1'b0, ypos};
        dx    = (h_ext >= x_ext) ? (h_ext - x_ext) : (x_ext - h_ext);
        dy    = (v_ext >= y_ext) ? (v_ext - y_ext) : (y_ext - v_ext);
        fill  = (dx <= HALF_W11) && (dy <= HALF_H11);
        rgb_d = !bright ? 12'h000 : (fill ? COLOR : background);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= 1'b0;
            xpos_q  <= 10'(X_START);
            score_q <= 16'd0;
            rgb_q   <= 12'h000;
        end else begin
            frame_q <= frame_d;
            xpos_q  <= xpos_d;
            score_q <= score_d;
            rgb_q   <= rgb_d;
        end
    end

    assign xpos      = xpos_q;
    assign score     = score_q;
    assign rgb       = rgb_q;
    assign state_dbg = jump_state;

endmodule

// File: tb/tb_rex_sprite_engine.sv
module tb_rex_sprite_engine;

  localparam logic [11:0] BG = 12'h0A5;
`ifdef REX_SCORE_BCD_EN
  localparam int          BURST   = 9994;
  localparam logic [15:0] PRE_EXP = 16'h9994;
  localparam logic [15:0] MAX_EXP = 16'h9999;
`else
  localparam int          BURST   = 65530;
  localparam logic [15:0] PRE_EXP = 16'hFFFA;
  localparam logic [15:0] MAX_EXP = 16'hFFFF;
`endif

  logic        clk;
  logic        rst;
  logic        up, down, left, right, pause;
  logic [9:0]  hCount, vCount;
  logic        bright;
  logic [11:0] background;
  logic [9:0]  xpos, ypos;
  logic [15:0] score;
  logic        airborne;
  logic [11:0] rgb;
  logic [1:0]  state_dbg;

  int checks;
  int failures;
  int max_x;
  int min_x;

  rex_sprite_engine dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .pause      (pause),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .background (background),
    .xpos       (xpos),
    .ypos       (ypos),
    .score      (score),
    .airborne   (airborne),
    .rgb        (rgb),
    .state_dbg  (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame tick: raster at (0,0) for one clock, then elsewhere.
  task automatic do_tick();
    hCount = 10'd0;
    vCount = 10'd0;
    @(negedge clk);
    hCount = 10'd1;
    vCount = 10'd1;
    @(negedge clk);
  endtask

  // n consecutive ticks by parking the raster at (0,0) for n clocks.
  task automatic burst_ticks(input int n);
    hCount = 10'd0;
    vCount = 10'd0;
    repeat (n) @(posedge clk);
    #1;
    hCount = 10'd1;
    vCount = 10'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; pause = 1'b0;
    hCount = 10'd1; vCount = 10'd1;
    bright = 1'b0; background = BG;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_xpos", 32'(xpos), 32'd450);
    chk("rst_ypos", 32'(ypos), 32'd400);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_airborne", 32'(airborne), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // full jump
    up = 1'b1;
    do_tick();
    up = 1'b0;
    chk("jump_start_air", 32'(airborne), 32'd1);
    chk("jump_start_y", 32'(ypos), 32'd400);
    chk("jump_start_st", 32'(state_dbg), 32'd1);
    repeat (12) do_tick();
    chk("jump_apex_y", 32'(ypos), 32'd322);
    chk("jump_apex_st", 32'(state_dbg), 32'd2);
    repeat (11) do_tick();
    chk("jump_fall11_y", 32'(ypos), 32'd388);
    chk("jump_fall11_air", 32'(airborne), 32'd1);
    do_tick();
    chk("jump_land_y", 32'(ypos), 32'd400);
    chk("jump_land_air", 32'(airborne), 32'd0);
    chk("score_25", 32'(score), 32'd25);

    // fast drop after 3 rise ticks
    up = 1'b1;
    do_tick();
    up = 1'b0;
    repeat (3) do_tick();
    chk("drop_pre_y", 32'(ypos), 32'd367);
    down = 1'b1;
    do_tick();
    down = 1'b0;
    chk("drop_y", 32'(ypos), 32'd358);
    chk("drop_st", 32'(state_dbg), 32'd2);
    repeat (3) do_tick();
    chk("drop_fall3_y", 32'(ypos), 32'd388);
    do_tick();
    chk("drop_land_y", 32'(ypos), 32'd400);
    chk("drop_land_air", 32'(airborne), 32'd0);
    chk("score_34", 32'(score), 32'd34);

    // horizontal motion and clamping
    right = 1'b1;
    repeat (10) do_tick();
    chk("right10_x", 32'(xpos), 32'd470);
    max_x = 0;
    for (int i = 0; i < 390; i++) begin
      do_tick();
      if (int'(xpos) > max_x) max_x = int'(xpos);
    end
    chk("right_max_x", 32'(max_x), 32'd778);
    chk("right_clamp_x", 32'(xpos), 32'd778);
    right = 1'b0;
    left = 1'b1;
    min_x = 1023;
    for (int i = 0; i < 400; i++) begin
      do_tick();
      if (int'(xpos) < min_x) min_x = int'(xpos);
    end
    chk("left_min_x", 32'(min_x), 32'd149);
    chk("left_clamp_x", 32'(xpos), 32'd149);
    left = 1'b0;
    chk("score_834", 32'(score), 32'd834);

    // pause freezes motion, jump and score
    pause = 1'b1; right = 1'b1; up = 1'b1;
    repeat (5) do_tick();
    chk("pause_x", 32'(xpos), 32'd149);
    chk("pause_air", 32'(airborne), 32'd0);
    chk("pause_score", 32'(score), 32'd834);
    pause = 1'b0; right = 1'b0; up = 1'b0;

    // pixel overlay, sprite at (149,400)
    bright = 1'b1;
    hCount = 10'd154; vCount = 10'd400;
    @(negedge clk);
    chk("pix_right_edge", 32'(rgb), 32'hF00);
    hCount = 10'd155;
    @(negedge clk);
    chk("pix_right_out", 32'(rgb), 32'(BG));
    hCount = 10'd144;
    @(negedge clk);
    chk("pix_left_edge", 32'(rgb), 32'hF00);
    hCount = 10'd149; vCount = 10'd395;
    @(negedge clk);
    chk("pix_top_edge", 32'(rgb), 32'hF00);
    vCount = 10'd394;
    @(negedge clk);
    chk("pix_top_out", 32'(rgb), 32'(BG));
    vCount = 10'd400; bright = 1'b0;
    @(negedge clk);
    chk("pix_blank", 32'(rgb), 32'd0);
    bright = 1'b1;
    hCount = 10'd1; vCount = 10'd1;

    // reset in the middle of a jump
    up = 1'b1;
    do_tick();
    up = 1'b0;
    repeat (3) do_tick();
    chk("midjump_air", 32'(airborne), 32'd1);
    chk("midjump_rgb", 32'(rgb), 32'(BG));
    #2 rst = 1'b0;
    #1;
    chk("midrst_xpos", 32'(xpos), 32'd450);
    chk("midrst_ypos", 32'(ypos), 32'd400);
    chk("midrst_score", 32'(score), 32'd0);
    chk("midrst_rgb", 32'(rgb), 32'd0);
    chk("midrst_air", 32'(airborne), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bright = 1'b0;
    @(negedge clk);

    // score saturation
    burst_ticks(BURST);
    chk("score_pre", 32'(score), 32'(PRE_EXP));
    repeat (5) do_tick();
    chk("score_max", 32'(score), 32'(MAX_EXP));
    repeat (2) do_tick();
    chk("score_hold", 32'(score), 32'(MAX_EXP));
    pause = 1'b1;
    repeat (2) do_tick();
    chk("score_pause", 32'(score), 32'(MAX_EXP));
    pause = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
